// File: rtl/pc_npc_unit_if.sv
// Fetch-stage PC/nPC bundle: next-nPC/control inputs and the PC-pair outputs.
// The DUT uses the slave modport; the driver of the controls uses master.
interface pc_npc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] npc_next;
  logic             stall;
  logic             annul_req;
  logic             trap_req;
  logic [WIDTH-1:0] trap_vec;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] npc;
  logic [WIDTH-1:0] npc_plus4;
  logic             pc_valid;
  logic             misalign;

  modport master (
    output npc_next, stall, annul_req, trap_req, trap_vec,
    input  pc, npc, npc_plus4, pc_valid, misalign
  );

  modport slave (
    input  npc_next, stall, annul_req, trap_req, trap_vec,
    output pc, npc, npc_plus4, pc_valid, misalign
  );
endinterface

// File: rtl/pc_npc_unit.sv
// SPARC PC/nPC pair with delayed-branch sequencing, stall hold, delay-slot
// annul, trap entry and registered next-nPC misalignment flag.
module pc_npc_unit #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  pc_npc_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] AddrStep = WIDTH'(4);

  typedef enum logic [1:0] {StBoot, StRun, StHold, StTrap} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             misalign_q, misalign_d;
  logic             active;

  // RUN and HOLD react identically to trap/stall; BOOT and TRAP ignore both.
  assign active = (state_q == StRun) || (state_q == StHold);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + AddrStep;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun, StHold: begin
        if (bus.trap_req)   state_d = StTrap;
        else if (bus.stall) state_d = StHold;
        else                state_d = StRun;
      end
      StTrap: state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    npc_d      = npc_q;
    pc_valid_d = pc_valid_q;
    misalign_d = misalign_q;
    if (state_q == StTrap) begin
      pc_valid_d = 1'b1;
    end else if (active && bus.trap_req) begin
      pc_d       = bus.trap_vec;
      npc_d      = bus.trap_vec + AddrStep;
      pc_valid_d = 1'b0;
      misalign_d = 1'b0;
    end else if (active && !bus.stall) begin
      pc_d       = npc_q;
      npc_d      = bus.npc_next;
      pc_valid_d = ~bus.annul_req;
      misalign_d = |bus.npc_next[1:0];
    end
  end

  assign bus.pc        = pc_q;
  assign bus.npc       = npc_q;
  assign bus.npc_plus4 = npc_q + AddrStep;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Scoreboard bench for pc_npc_unit: a stimulus process pushes reference-model
// results per clock, a monitor pops and compares them after each rising edge.
module tb_pc_npc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
    logic        mis;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  bit   mon_en;
  exp_t exp_q[$];

  // Reference model: architectural PC pair plus "boot cycle pending" and
  // "in trap cycle" flags; everything else follows the update rules directly.
  logic [31:0] m_pc, m_npc;
  logic        m_valid, m_mis;
  bit          m_boot, m_trap;

  pc_npc_unit_if #(.WIDTH(32)) bus ();

  pc_npc_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_npc   = 32'h4;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_boot  = 1'b1;
    m_trap  = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs on the falling edge, record the expected
  // post-edge state, then return shortly after the rising edge.
  task automatic step(input bit use_p4, input logic [31:0] nn, input bit st,
                      input bit an, input bit tr, input logic [31:0] tv);
    logic [31:0] nn_eff;
    @(negedge clk);
    nn_eff        = use_p4 ? m_npc + 32'd4 : nn;
    bus.npc_next  = nn_eff;
    bus.stall     = st;
    bus.annul_req = an;
    bus.trap_req  = tr;
    bus.trap_vec  = tv;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_trap) begin
      m_trap  = 1'b0;
      m_valid = 1'b1;
    end else if (tr) begin
      m_pc    = tv;
      m_npc   = tv + 32'd4;
      m_valid = 1'b0;
      m_mis   = 1'b0;
      m_trap  = 1'b1;
    end else if (!st) begin
      m_pc    = m_npc;
      m_npc   = nn_eff;
      m_valid = ~an;
      m_mis   = |nn_eff[1:0];
    end
    exp_q.push_back('{pc: m_pc, npc: m_npc, valid: m_valid, mis: m_mis});
    @(posedge clk);
    #2;
  endtask

  task automatic seq(int n);
    for (int i = 0; i < n; i++) step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic chk_pair(input string name, input logic [31:0] p, input logic [31:0] n,
                          input logic v);
    chk({name, "_pc"}, bus.pc, p);
    chk({name, "_npc"}, bus.npc, n);
    chk({name, "_valid"}, {31'b0, bus.pc_valid}, {31'b0, v});
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_empty: got no expectation want one at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("mon_pc", bus.pc, e.pc);
        chk("mon_npc", bus.npc, e.npc);
        chk("mon_valid", {31'b0, bus.pc_valid}, {31'b0, e.valid});
        chk("mon_misalign", {31'b0, bus.misalign}, {31'b0, e.mis});
        chk("mon_npc_plus4", bus.npc_plus4, e.npc + 32'd4);
      end
    end
  end

  initial begin
    total         = 0;
    bad           = 0;
    mon_en        = 1'b0;
    reset_n       = 1'b0;
    bus.npc_next  = '0;
    bus.stall     = 1'b0;
    bus.annul_req = 1'b0;
    bus.trap_req  = 1'b0;
    bus.trap_vec  = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #2;
    chk_pair("reset", 32'h0, 32'h4, 1'b0);
    chk("reset_misalign", {31'b0, bus.misalign}, 32'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Boot cycle, then sequential fetch.
    seq(1);
    chk_pair("boot", 32'h0, 32'h4, 1'b0);
    seq(1);
    chk_pair("run1", 32'h4, 32'h8, 1'b1);
    seq(1);
    chk_pair("run2", 32'h8, 32'hC, 1'b1);
    seq(2);

    // Delayed branch at pc=0x10.
    step(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_pair("dslot", 32'h14, 32'h100, 1'b1);
    seq(1);
    chk_pair("btgt", 32'h100, 32'h104, 1'b1);

    // Annul the slot following pc=0x20.
    step(1'b0, 32'h1C, 1'b0, 1'b0, 1'b0, 32'h0);
    seq(2);
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_pair("annul", 32'h24, 32'h28, 1'b0);
    seq(1);
    chk_pair("post_annul", 32'h28, 32'h2C, 1'b1);

    // Stall three cycles at pc=0x40; npc_next and annul_req must be ignored.
    step(1'b0, 32'h3C, 1'b0, 1'b0, 1'b0, 32'h0);
    seq(2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'hDEAD_BEE0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk_pair("stall", 32'h40, 32'h44, 1'b1);
    end
    seq(1);
    chk_pair("unstall", 32'h44, 32'h48, 1'b1);

    // Trap during stall; a second trap_req in the TRAP cycle is ignored.
    step(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h800);
    chk_pair("trap", 32'h800, 32'h804, 1'b0);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h900);
    chk_pair("trap_cyc", 32'h800, 32'h804, 1'b1);
    seq(1);
    chk_pair("post_trap", 32'h804, 32'h808, 1'b1);

    // Misalignment flag and npc_plus4 wrap.
    step(1'b0, 32'h102, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("mis_npc", bus.npc, 32'h102);
    chk("mis_flag", {31'b0, bus.misalign}, 32'h1);
    step(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_npc", bus.npc, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus.npc_plus4, 32'h0);
    chk("wrap_mis", {31'b0, bus.misalign}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] nn;
      nn = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 9) < 6, nn, $urandom_range(0, 3) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 99) < 5,
           $urandom() & 32'hFFFF_FFFC);
    end

    // Asynchronous reset mid-run, observed before the next clock edge.
    step(1'b0, 32'h0000_1230, 1'b0, 1'b0, 1'b0, 32'h0);
    seq(1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_pair("async_rst", 32'h0, 32'h4, 1'b0);
    chk("async_rst_mis", {31'b0, bus.misalign}, 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    seq(1);
    chk_pair("reboot", 32'h0, 32'h4, 1'b0);
    seq(2);
    chk_pair("rerun", 32'h8, 32'hC, 1'b1);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- Holds the SPARC program counter pair (PC, nPC) for the fetch stage, directly downstream of mux_4x1_32bit.
- The 4x1 mux selects the next-nPC source: I0 = npc_plus4 (driven by this block), I1 = branch target, I2 = jmpl target, I3 = trap vector. Its Y output feeds npc_next here.
- Implements delayed-branch sequencing (PC<=nPC, nPC<=npc_next), stall hold, delay-slot annul, trap entry and misalignment detection.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- npc_next  input  WIDTH  next-nPC value from mux_4x1_32bit Y.
- stall  input  1  hold PC/nPC and state this cycle.
- annul_req  input  1  annul the instruction at the next PC (branch with a=1 not taken, or ba,a).
- trap_req  input  1  external trap request; has priority over stall.
- trap_vec  input  WIDTH  trap target address (TBR-formed).
- pc  output  WIDTH  current fetch address.
- npc  output  WIDTH  current nPC.
- npc_plus4  output  WIDTH  combinational npc+4, feeds mux I0.
- pc_valid  output  1  high when the instruction at pc is to be executed (low = bubble/annulled).
- misalign  output  1  registered flag: the npc_next captured last update had bits[1:0] != 0.

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, npc=RESET_PC+4, pc_valid=0, misalign=0, state=BOOT. Reset asserted mid-operation overrides everything immediately.
- npc_plus4 = npc + 4, modulo 2^WIDTH (wraps silently at 32'hFFFF_FFFC -> 0).
- States: BOOT, RUN, HOLD, TRAP.
- BOOT: one cycle after reset release; pc/npc unchanged, pc_valid stays 0 -> RUN next cycle. trap_req and stall are ignored in BOOT.
- RUN, update cycle (no stall, no trap): pc<=npc; npc<=npc_next; pc_valid<=~annul_req; misalign<=|npc_next[1:0]. Latency: npc_next appears on npc 1 cycle later and on pc 2 cycles later.
- RUN with stall=1 and trap_req=0: go to HOLD. pc, npc, pc_valid, misalign hold. annul_req and npc_next are ignored.
- HOLD: holds while stall=1. When stall=0, performs the normal RUN update in that same cycle and returns to RUN.
- trap_req=1 in RUN or HOLD (stall ignored): pc<=trap_vec; npc<=trap_vec+4; pc_valid<=0; misalign<=0; state->TRAP.
- TRAP: one cycle. pc/npc hold, pc_valid<=1 -> RUN. A trap_req during TRAP is ignored (no nested trap entry).
- Simultaneous events:
  - trap_req beats stall, and beats annul_req.
  - annul_req with stall is discarded; the upstream must re-assert it on the cycle stall drops.
- misalign is informational only. The block never self-traps; the trap controller samples misalign and raises trap_req.
- pc and npc are registered outputs. npc_plus4 is the only combinational output.

Test Plan:
- Reset/boot: hold reset_n=0, then release; npc_next = npc_plus4 -> pc=0, npc=4, pc_valid=0 for the BOOT cycle; then pc=4, npc=8, pc_valid=1; then pc=8, npc=12.
- Delayed branch: at pc=0x10, npc=0x14, drive npc_next=0x100 for one update -> pc=0x14 (delay slot, valid); next cycle pc=0x100, npc=0x104.
- Annul: annul_req=1 on the update with pc=0x20 -> pc=0x24 with pc_valid=0; next cycle pc=0x28 with pc_valid=1.
- Stall: stall=1 for 3 cycles at pc=0x40 -> pc/npc stay 0x40/0x44 throughout; first cycle after stall drops -> pc=0x44.
- Trap during stall: stall=1, trap_req=1, trap_vec=0x800 -> pc=0x800, npc=0x804, pc_valid=0; next cycle pc_valid=1; then pc=0x804.
- Misalign and wrap:
  - npc_next=0x102 -> misalign=1 on the same edge that npc=0x102.
  - npc=0xFFFF_FFFC -> npc_plus4=0x0000_0000.
  - reset_n pulsed low mid-RUN -> outputs return to reset values asynchronously, before the next clock edge.
